avg_frame_ctrl: RTL and testbench
=================================

AVG_FRAME_CTRL -- requirements
Module: avg_frame_ctrl

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 16'd50000: maximum RUN-state cycles before abort.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- vggo  in  1  one-cycle CPU VGGO strobe.
- vgrst  in  1  one-cycle CPU VGRST strobe.
- core_halt  in  1  avg_core has executed HALT.
- core_go  out  1  enables avg_core instruction execution.
- core_rst  out  1  one-cycle synchronous restart of avg_core PC and state.
- q_empty  in  1  lineRegQueue empty.
- q_read  out  1  pops lineRegQueue head.
- q_flush  out  1  one-cycle clear of lineRegQueue.
- draw_ready  in  1  line drawer accepts the queue head this cycle.
- draw_idle  in  1  line drawer has no line in progress.
- draw_valid  out  1  queue head is offered to the drawer.
- vg_halt  out  1  CPU status: vector generator idle.
- frame_cnt  out  8  completed frames, wraps 255->0.
- wdog_err  out  1  sticky: last frame aborted by watchdog.
- go_ovr  out  1  sticky: vggo arrived while not IDLE.

Function
REQ-003 SHALL implement the states IDLE, START, RUN and DRAIN.
REQ-004 In IDLE, vggo SHALL move to START.
REQ-005 START SHALL last exactly one cycle with core_rst=1, then go to RUN.
REQ-006 In RUN, core_go SHALL be 1 and a 16-bit watchdog SHALL increment each cycle; it clears on entry to START.
REQ-007 In RUN, core_halt=1 SHALL move to DRAIN on the next edge; core_go is 0 from that edge.
REQ-008 In RUN, watchdog==WDOG_MAX-1 with core_halt=0 SHALL set wdog_err and move to DRAIN.
REQ-009 When core_halt and the watchdog limit coincide, the state SHALL go to DRAIN with wdog_err unchanged, because halt wins.
REQ-010 In DRAIN, q_empty=1 and draw_idle=1 in the same cycle SHALL move to IDLE and increment frame_cnt by 1, modulo 256.
REQ-011 core_go SHALL be 1 only in RUN.
REQ-012 core_rst SHALL be 1 only in START or the cycle after vgrst is sampled.
REQ-013 vg_halt SHALL be 1 only in IDLE.
REQ-014 Pop handshake:
- draw_valid = !q_empty while in START, RUN or DRAIN; 0 in IDLE.
- q_read = draw_valid & draw_ready, combinational; one pop per cycle.
- No pop SHALL occur when q_empty=1.
REQ-015 vggo in any state other than IDLE SHALL be ignored for sequencing and SHALL set go_ovr.
REQ-016 vgrst in any state SHALL, on the next edge:
- go to IDLE;
- pulse core_rst and q_flush for one cycle;
- clear wdog_err, go_ovr and the watchdog.
frame_cnt SHALL be preserved.
REQ-017 When vgrst and vggo are sampled in the same cycle, vgrst SHALL win and vggo SHALL be dropped without setting go_ovr.
REQ-018 wdog_err and go_ovr SHALL also clear on entry to START.
REQ-019 Outputs other than q_read and draw_valid SHALL be registered.

Reset
REQ-020 While rst=1, the following SHALL hold immediately, without waiting for a clock edge:
- state=IDLE;
- core_go=0, core_rst=0, q_flush=0, draw_valid=0, q_read=0;
- vg_halt=1, frame_cnt=0, wdog_err=0, go_ovr=0;
- watchdog=0.
REQ-021 Deassertion of rst SHALL take effect at the first clk edge after it; a vggo in that cycle SHALL be honoured.
REQ-022 rst asserted mid-frame (RUN or DRAIN) SHALL abort immediately to the REQ-020 values, with no q_flush pulse.

Verification
REQ-023 Basic frame:
- Stimulus: vggo in IDLE; 3 lines enqueued; draw_ready=1; core_halt after 40 RUN cycles; draw_idle=1 once the queue drains.
- Response: core_rst high 1 cycle, then core_go high 40 cycles; 3 q_read pulses; return to IDLE; frame_cnt=1; vg_halt=1.
REQ-024 Watchdog:
- Stimulus: WDOG_MAX=16; vggo; core_halt held 0.
- Response: core_go drops after 16 RUN cycles; wdog_err=1; DRAIN then IDLE; frame_cnt increments.
REQ-025 Backpressure:
- Stimulus: draw_ready=0 with q_empty=0, held for 10 cycles.
- Response: draw_valid=1 and q_read=0 throughout; DRAIN does not exit until the pops complete and draw_idle=1.
REQ-026 Strobe collision:
- Stimulus: vggo during RUN; later, vgrst and vggo in the same cycle.
- Response: go_ovr=1 after the first; after the second, IDLE with q_flush and core_rst pulsed once and go_ovr=0.
REQ-027 Async reset:
- Stimulus: rst pulsed mid-RUN, off a clock edge.
- Response: outputs reach the REQ-020 values before the next edge.
- Stimulus: frame_cnt at 255, then one more frame.
- Response: frame_cnt=0.

Source files
------------

// File: rtl/avg_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : avg_frame_ctrl
// Purpose  : Frame sequencer: starts/stops avg_core, feeds the line drawer,
//            counts frames and guards a RUN phase with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module avg_frame_ctrl #(
   parameter logic [15:0] WDOG_MAX = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vggo,
   input  logic       vgrst,
   input  logic       core_halt,
   output logic       core_go,
   output logic       core_rst,
   input  logic       q_empty,
   output logic       q_read,
   output logic       q_flush,
   input  logic       draw_ready,
   input  logic       draw_idle,
   output logic       draw_valid,
   output logic       vg_halt,
   output logic [7:0] frame_cnt,
   output logic       wdog_err,
   output logic       go_ovr
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t      r_state;
   logic [15:0] r_wdog;
   logic        w_active;

   assign w_active   = (r_state != S_IDLE);
   assign draw_valid = w_active & ~q_empty;
   assign q_read     = draw_valid & draw_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_wdog    <= 16'd0;
         core_go   <= 1'b0;
         core_rst  <= 1'b0;
         q_flush   <= 1'b0;
         vg_halt   <= 1'b1;
         frame_cnt <= 8'd0;
         wdog_err  <= 1'b0;
         go_ovr    <= 1'b0;
      end else begin
         core_rst <= 1'b0;
         q_flush  <= 1'b0;
         if (vgrst) begin
            // vgrst overrides everything, including a coincident vggo
            r_state  <= S_IDLE;
            r_wdog   <= 16'd0;
            core_go  <= 1'b0;
            core_rst <= 1'b1;
            q_flush  <= 1'b1;
            vg_halt  <= 1'b1;
            wdog_err <= 1'b0;
            go_ovr   <= 1'b0;
         end else begin
            if (vggo && w_active) begin
               go_ovr <= 1'b1;
            end
            case (r_state)
               S_IDLE: begin
                  if (vggo) begin
                     r_state  <= S_START;
                     r_wdog   <= 16'd0;
                     core_rst <= 1'b1;
                     vg_halt  <= 1'b0;
                     wdog_err <= 1'b0;
                     go_ovr   <= 1'b0;
                  end
               end
               S_START: begin
                  r_state <= S_RUN;
                  core_go <= 1'b1;
               end
               S_RUN: begin
                  // halt is checked first so a coincident limit is not an error
                  if (core_halt) begin
                     r_state <= S_DRAIN;
                     core_go <= 1'b0;
                  end else if (r_wdog == WDOG_MAX - 16'd1) begin
                     r_state  <= S_DRAIN;
                     core_go  <= 1'b0;
                     wdog_err <= 1'b1;
                  end else begin
                     r_wdog <= r_wdog + 16'd1;
                  end
               end
               S_DRAIN: begin
                  if (q_empty && draw_idle) begin
                     r_state   <= S_IDLE;
                     vg_halt   <= 1'b1;
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  core_go <= 1'b0;
                  vg_halt <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_avg_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_avg_frame_ctrl
// Purpose  : Self-checking bench for avg_frame_ctrl (default and short watchdog).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avg_frame_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vggo = 1'b0, vgrst = 1'b0, core_halt = 1'b0, draw_ready = 1'b0;
   bit   busy = 1'b0;
   int   qn [2] = '{0, 0};

   logic q_empty0, q_empty1, didle0, didle1;
   assign q_empty0 = (qn[0] == 0);
   assign q_empty1 = (qn[1] == 0);
   assign didle0   = (qn[0] == 0) && !busy;
   assign didle1   = (qn[1] == 0) && !busy;

   logic       a_go, a_rs, a_rd, a_fl, a_dv, a_vh, a_we, a_ov;
   logic       b_go, b_rs, b_rd, b_fl, b_dv, b_vh, b_we, b_ov;
   logic [7:0] a_fc, b_fc;

   always #5 clk = ~clk;

   avg_frame_ctrl u_dut0 (
      .clk(clk), .rst(rst), .vggo(vggo), .vgrst(vgrst), .core_halt(core_halt),
      .core_go(a_go), .core_rst(a_rs), .q_empty(q_empty0), .q_read(a_rd),
      .q_flush(a_fl), .draw_ready(draw_ready), .draw_idle(didle0),
      .draw_valid(a_dv), .vg_halt(a_vh), .frame_cnt(a_fc), .wdog_err(a_we),
      .go_ovr(a_ov)
   );

   avg_frame_ctrl #(.WDOG_MAX(16'd16)) u_dut1 (
      .clk(clk), .rst(rst), .vggo(vggo), .vgrst(vgrst), .core_halt(core_halt),
      .core_go(b_go), .core_rst(b_rs), .q_empty(q_empty1), .q_read(b_rd),
      .q_flush(b_fl), .draw_ready(draw_ready), .draw_idle(didle1),
      .draw_valid(b_dv), .vg_halt(b_vh), .frame_cnt(b_fc), .wdog_err(b_we),
      .go_ovr(b_ov)
   );

   // Reference model: phase 0=idle 1=start 2=run 3=drain, plus registered outputs
   typedef struct {
      int ph; int wd; int fc;
      bit we; bit ov; bit go; bit rs; bit fl; bit vh;
   } mdl_t;
   mdl_t m [2];
   int   wmax [2] = '{50000, 16};

   int n_vec = 0, n_err = 0, cyc = 0;
   int go_cnt [2];
   int pop_cnt [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] obsv(input int i);
      if (i == 0) return {a_go, a_rs, a_fl, a_dv, a_rd, a_vh, a_fc, a_we, a_ov};
      return {b_go, b_rs, b_fl, b_dv, b_rd, b_vh, b_fc, b_we, b_ov};
   endfunction

   function automatic logic [15:0] expv(input int i);
      logic       dv;
      logic [7:0] f;
      dv = (m[i].ph != 0) && (qn[i] != 0);
      f  = m[i].fc[7:0];
      return {m[i].go, m[i].rs, m[i].fl, dv, dv && draw_ready, m[i].vh, f, m[i].we, m[i].ov};
   endfunction

   task automatic mreset();
      for (int i = 0; i < 2; i++) begin
         m[i].ph = 0; m[i].wd = 0; m[i].fc = 0;
         m[i].we = 0; m[i].ov = 0; m[i].go = 0; m[i].rs = 0; m[i].fl = 0; m[i].vh = 1;
      end
   endtask

   task automatic mstep(input int i);
      bit qe, di, pop, flp;
      int nph;
      qe  = (qn[i] == 0);
      di  = qe && !busy;
      pop = (m[i].ph != 0) && !qe && draw_ready;
      flp = m[i].fl;
      nph = m[i].ph;
      m[i].rs = 0;
      m[i].fl = 0;
      if (vgrst) begin
         nph = 0; m[i].rs = 1; m[i].fl = 1; m[i].we = 0; m[i].ov = 0; m[i].wd = 0;
      end else begin
         if (vggo && m[i].ph != 0) m[i].ov = 1;
         if (m[i].ph == 0) begin
            if (vggo) begin
               nph = 1; m[i].wd = 0; m[i].we = 0; m[i].ov = 0; m[i].rs = 1;
            end
         end else if (m[i].ph == 1) begin
            nph = 2;
         end else if (m[i].ph == 2) begin
            if (core_halt) nph = 3;
            else if (m[i].wd == wmax[i] - 1) begin nph = 3; m[i].we = 1; end
            else m[i].wd++;
         end else begin
            if (qe && di) begin nph = 0; m[i].fc = (m[i].fc + 1) % 256; end
         end
      end
      m[i].ph = nph;
      m[i].go = (nph == 2);
      m[i].vh = (nph == 0);
      if (pop) qn[i]--;
      if (flp) qn[i] = 0;
   endtask

   // One clock: compare everything mid-cycle, then advance model after the edge
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk($sformatf("cyc%0d_u%0d", cyc, i), obsv(i), expv(i));
      go_cnt[0]  += int'(a_go);
      go_cnt[1]  += int'(b_go);
      pop_cnt[0] += int'(a_rd);
      pop_cnt[1] += int'(b_rd);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) mstep(i);
      cyc++;
   endtask

   task automatic wait_idle0(input string tag);
      for (int k = 0; k < 50 && !a_vh; k++) tick();
      chk(tag, a_vh, 1'b1);
   endtask

   task automatic enq(input int n);
      qn[0] += n;
      qn[1] += n;
   endtask

   task automatic frame();
      vggo = 1'b1; tick(); vggo = 1'b0;
      tick(); tick(); tick();
   endtask

   initial begin
      mreset();
      @(posedge clk);
      #2;
      chk("reset_u0", obsv(0), expv(0));
      chk("reset_u1", obsv(1), expv(1));
      #1 rst = 1'b0;

      // Basic frame on u0 (halt after 40 RUN cycles); u1 hits its 16-cycle watchdog
      enq(3);
      draw_ready = 1'b1;
      go_cnt = '{0, 0};
      pop_cnt = '{0, 0};
      vggo = 1'b1; tick(); vggo = 1'b0;
      chk("start_core_rst", a_rs, 1'b1);
      chk("start_core_go", a_go, 1'b0);
      tick();
      for (int k = 1; k <= 40; k++) begin
         core_halt = (k == 40);
         tick();
      end
      core_halt = 1'b0;
      chk("halt_core_go_low", a_go, 1'b0);
      wait_idle0("basic_idle");
      chk("basic_go_cycles", go_cnt[0], 40);
      chk("basic_pops", pop_cnt[0], 3);
      chk("basic_frame_cnt", a_fc, 8'd1);
      chk("basic_wdog_err", a_we, 1'b0);
      chk("wdog_go_cycles", go_cnt[1], 16);
      chk("wdog_err_set", b_we, 1'b1);
      chk("wdog_frame_cnt", b_fc, 8'd1);
      chk("wdog_idle", b_vh, 1'b1);

      // Backpressure: queue stalled for 10 cycles, then drawer stays busy
      draw_ready = 1'b0;
      enq(2);
      core_halt = 1'b1;
      vggo = 1'b1; tick(); vggo = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("bp_valid_%0d", k), a_dv, 1'b1);
         chk($sformatf("bp_read_%0d", k), a_rd, 1'b0);
         tick();
      end
      core_halt = 1'b0;
      busy = 1'b1;
      draw_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("bp_still_drain", a_vh, 1'b0);
      busy = 1'b0;
      wait_idle0("bp_idle");
      chk("bp_frame_cnt", a_fc, 8'd2);

      // Strobe collision: vggo in RUN, then vgrst+vggo together
      vggo = 1'b1; tick(); vggo = 1'b0;
      tick(); tick(); tick();
      vggo = 1'b1; tick(); vggo = 1'b0;
      chk("ovr_set", a_ov, 1'b1);
      chk("ovr_busy", a_vh, 1'b0);
      tick();
      vgrst = 1'b1; vggo = 1'b1; tick(); vgrst = 1'b0; vggo = 1'b0;
      chk("col_core_rst", a_rs, 1'b1);
      chk("col_flush", a_fl, 1'b1);
      chk("col_ovr_clr", a_ov, 1'b0);
      chk("col_idle", a_vh, 1'b1);
      tick();
      chk("col_flush_once", a_fl, 1'b0);
      chk("col_rst_once", a_rs, 1'b0);
      chk("col_frame_kept", a_fc, 8'd2);

      // Asynchronous reset mid-RUN, released with a vggo in the same cycle
      enq(2);
      draw_ready = 1'b0;
      vggo = 1'b1; tick(); vggo = 1'b0;
      tick(); tick();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      mreset();
      chk("async_u0", obsv(0), expv(0));
      chk("async_u1", obsv(1), expv(1));
      @(posedge clk);
      #3;
      rst = 1'b0;
      vggo = 1'b1;
      tick();
      vggo = 1'b0;
      chk("rel_vggo_honoured", a_rs, 1'b1);
      draw_ready = 1'b1;
      core_halt = 1'b1;
      wait_idle0("rel_idle");

      // frame_cnt wrap 255 -> 0
      qn = '{0, 0};
      for (int k = 0; k < 300 && m[0].fc != 255; k++) frame();
      chk("wrap_255", a_fc, 8'd255);
      frame();
      chk("wrap_0", a_fc, 8'd0);
      core_halt = 1'b0;

      // Randomized traffic, every cycle checked against the model
      for (int k = 0; k < 600; k++) begin
         draw_ready = 1'($urandom_range(0, 1));
         vggo       = ($urandom_range(0, 11) == 0);
         vgrst      = ($urandom_range(0, 79) == 0);
         core_halt  = ($urandom_range(0, 9) == 0);
         busy       = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) enq(1);
         tick();
      end
      vggo = 1'b0; vgrst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
